serial_chain_shifter: RTL and testbench

SERIAL_CHAIN_SHIFTER -- requirements
Module: serial_chain_shifter

---
 rtl/serial_chain_shifter.sv | 111 +++++++++++
 tb/tb_serial_chain_shifter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chain_shifter.sv
// serial_chain_shifter: streams a parallel frame into daisy-chained shift registers, then pulses the latch
module serial_chain_shifter #(
  parameter int WIDTH = 8,
  parameter int WORDS = 2,
  parameter bit LSB_FIRST = 1'b0,
  parameter int LATCH_TICKS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clk_stb,
  input  logic                     i_start_stb,
  input  logic [WIDTH*WORDS-1:0]   i_parallel_data,
  output logic                     o_busy,
  output logic                     o_pending,
  output logic                     o_done_stb,
  output logic                     o_serial_data,
  output logic                     o_serial_clk,
  output logic                     o_serial_latch
);
  localparam int N = WIDTH * WORDS;
  localparam int CW = $clog2(2 * N + 1);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);
  localparam logic [CW-1:0] HOLD = CW'(LATCH_TICKS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  state_t state, state_nxt;
  logic [N-1:0] ord, shreg, pend_buf, shifted;
  logic [CW-1:0] cnt;
  logic pending, last_bit, latch_end, load_new, load_pend, store_pend;
  // frames are reordered on capture so the shift register always emits its MSB first
  for (genvar i = 0; i < N; i++) begin : g_ord
    assign ord[N-1-i] = i_parallel_data[(WORDS-1-i/WIDTH)*WIDTH + (LSB_FIRST ? i%WIDTH : WIDTH-1-i%WIDTH)];
  end
  assign shifted = shreg << 1;
  assign last_bit = state == SHIFT && i_clk_stb && o_serial_clk && cnt == LAST;
  assign latch_end = state == LATCH && i_clk_stb && o_serial_latch && cnt == HOLD;
  assign o_busy = state != IDLE;
  assign o_pending = pending;
  // next state and frame hand-off; a start on the closing strobe with an empty buffer becomes the next frame
  always_comb begin
    state_nxt = state;
    load_new = 1'b0;
    load_pend = 1'b0;
    store_pend = state != IDLE && i_start_stb && !pending && !latch_end;
    case (state)
      IDLE: begin
        load_new = i_start_stb;
        state_nxt = i_start_stb ? LOAD : IDLE;
      end
      LOAD: state_nxt = SHIFT;
      SHIFT: state_nxt = last_bit ? LATCH : SHIFT;
      LATCH: if (latch_end) begin
        load_pend = pending;
        load_new = !pending && i_start_stb;
        state_nxt = (pending || i_start_stb) ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  // one-deep pending frame buffer
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending <= 1'b0;
      pend_buf <= '0;
    end else if (load_pend) begin
      pending <= 1'b0;
    end else if (store_pend) begin
      pending <= 1'b1;
      pend_buf <= ord;
    end
  end
  // serial datapath: data moves only on the falling toggle, latch counts strobes after the last bit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg <= '0;
      cnt <= '0;
      o_serial_clk <= 1'b0;
      o_serial_data <= 1'b0;
      o_serial_latch <= 1'b0;
      o_done_stb <= 1'b0;
    end else begin
      o_done_stb <= latch_end;
      if (load_new) shreg <= ord;
      else if (load_pend) shreg <= pend_buf;
      case (state)
        LOAD: begin
          o_serial_clk <= 1'b0;
          o_serial_data <= shreg[N-1];
          cnt <= '0;
        end
        SHIFT: if (i_clk_stb) begin
          o_serial_clk <= !o_serial_clk;
          cnt <= last_bit ? '0 : cnt + 1'b1;
          if (o_serial_clk) begin
            shreg <= shifted;
            o_serial_data <= last_bit ? 1'b0 : shifted[N-1];
          end
        end
        LATCH: if (i_clk_stb) begin
          o_serial_latch <= !latch_end;
          cnt <= (o_serial_latch && !latch_end) ? cnt + 1'b1 : '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_chain_shifter.sv
// tb_serial_chain_shifter: random and directed frames on two configurations against a strobe-budget model
module tb_serial_chain_shifter;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst_n, stb, start, stb_en;
  logic [15:0] din;
  logic [1:0] busy, pending, done, sd, sc, sl;
  logic [15:0] last [2];
  int ndone [2];
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] snap;
  int d0, d1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // expected wire order: word 1 then word 0, each MSB- or LSB-first; first bit lands in the result MSB
  function automatic logic [15:0] order(input logic [15:0] d, input int lsb);
    logic [15:0] o;
    int w, b;
    o = '0;
    for (int i = 0; i < N; i++) begin
      w = 1 - i / 8;
      b = i % 8;
      o = {o[14:0], 1'(d >> (w * 8 + (lsb != 0 ? b : 7 - b)))};
    end
    return o;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int T = (g == 0) ? 1 : 3;
    bit act, pend, dexp, ended, psc, psd;
    int dly, rem, nb, lc;
    logic [15:0] pdata, stream, expf;
    logic [15:0] q[$];

    serial_chain_shifter #(.WIDTH(8), .WORDS(2), .LSB_FIRST(g == 1), .LATCH_TICKS(T)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_clk_stb(stb), .i_start_stb(start),
      .i_parallel_data(din), .o_busy(busy[g]), .o_pending(pending[g]), .o_done_stb(done[g]),
      .o_serial_data(sd[g]), .o_serial_clk(sc[g]), .o_serial_latch(sl[g]));

    // model: a frame consumes one ignored cycle, then 2N + 1 + T strobes
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        act = 0; pend = 0; dexp = 0; dly = 0; rem = 0;
        q.delete();
      end else begin
        ended = 0;
        if (!act) begin
          if (start) begin
            act = 1; dly = 1; rem = 2 * N + 1 + T;
            q.push_back(din);
          end
        end else begin
          if (dly > 0) dly--;
          else if (stb) begin
            rem--;
            ended = (rem == 0);
          end
          if (ended) begin
            if (pend) begin
              pend = 0; dly = 1; rem = 2 * N + 1 + T;
              q.push_back(pdata);
            end else if (start) begin
              dly = 1; rem = 2 * N + 1 + T;
              q.push_back(din);
            end else act = 0;
          end else if (start && !pend) begin
            pend = 1; pdata = din;
          end
        end
        dexp = ended;
      end
    end

    // monitor: pins against the model, serial stream against the accepted-frame queue
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; lc = 0; stream = '0; psc = 0; psd = 0;
      end else begin
        check("busy", busy[g], act);
        check("pending", pending[g], pend);
        check("done", done[g], dexp);
        if (!busy[g]) check("idle_pins", {sd[g], sc[g], sl[g]}, 0);
        if (sl[g]) check("sclk_in_latch", sc[g], 0);
        if (sd[g] !== psd) check("data_edge", sc[g], 0);
        if (sc[g] && !psc) begin
          stream = {stream[14:0], sd[g]};
          nb++;
        end
        if (sl[g] && stb) lc++;
        if (done[g]) begin
          if (q.size() > 0) begin
            expf = order(q.pop_front(), g);
            check("frame", stream, expf);
          end else check("frame_queue", q.size(), 1);
          check("bits", nb, N);
          check("latch_strobes", lc, T);
          last[g] = stream;
          ndone[g]++;
          nb = 0; lc = 0; stream = '0;
        end
        psc = sc[g];
        psd = sd[g];
      end
    end
  end

  task automatic send(input logic [15:0] d);
    @(posedge clk);
    #1;
    start = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy == 2'b00) return;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    stb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stb = stb_en && ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    ndone[0] = 0;
    ndone[1] = 0;
    rst_n = 1'b0;
    start = 1'b0;
    din = '0;
    stb_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stb_en = 1'b1;
    @(negedge clk);
    check("reset_state", {busy, pending, done, sd, sc, sl}, 0);

    send(16'hA5C3);
    wait_idle();
    check("a5c3_msb", last[0], 16'b1010_0101_1100_0011);
    check("a5c3_done", ndone[0], 1);

    send(16'h0180);
    wait_idle();
    check("0180_lsb", last[1], 16'b1000_0000_0000_0001);

    d0 = ndone[0];
    d1 = ndone[1];
    send(16'h1234);
    repeat (10) @(posedge clk);
    send(16'h5678);
    @(negedge clk);
    check("pend_set", pending, 2'b11);
    send(16'h9ABC);
    wait_idle();
    check("two_done0", ndone[0] - d0, 2);
    check("two_done1", ndone[1] - d1, 2);
    check("follow0", last[0], order(16'h5678, 0));
    check("follow1", last[1], order(16'h5678, 1));

    send(16'h3C5A);
    repeat (20) @(posedge clk);
    #1;
    stb_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    snap = {sd, sc, sl, busy, pending, done};
    check("freeze_busy", busy, 2'b11);
    repeat (100) begin
      @(negedge clk);
      check("freeze", {sd, sc, sl, busy, pending, done}, snap);
    end
    stb_en = 1'b1;
    wait_idle();
    check("after_freeze0", last[0], order(16'h3C5A, 0));

    d0 = ndone[0];
    send(16'hBEEF);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, pending, done, sd, sc, sl}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    din = 16'h0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("first_start", busy, 2'b11);
    wait_idle();
    check("no_done_on_abort", ndone[0] - d0, 1);
    check("post_reset_frame", last[0], order(16'h0F0F, 0));

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 19) == 0);
      din = 16'($urandom);
    end
    start = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
